// File: rtl/microwave_control.sv
// Microwave cooking controller: turns keypad presses into timer digit loads, runs the
// cook/pause/done FSM, gates the magnetron and issues per-second count enables to the timer.
module microwave_control #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned BEEP_SECS     = 3
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] data,
    output logic       loadn,
    output logic       timer_clear,
    output logic       en,
    output logic       mag_on,
    output logic       done_beep,
    output logic [1:0] state
);

    localparam int unsigned BeepCycles = BEEP_SECS * TICKS_PER_SEC;
    localparam int unsigned CntW       = $clog2(TICKS_PER_SEC);
    localparam int unsigned BeepW      = $clog2(BeepCycles);
    localparam logic [CntW-1:0]  CntMax  = CntW'(TICKS_PER_SEC - 1);
    localparam logic [BeepW-1:0] BeepMax = BeepW'(BeepCycles - 1);

    typedef enum logic [1:0] {
        StSet     = 2'd0,
        StCooking = 2'd1,
        StPaused  = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [9:0]       key_s_q, key_prev_q;
    logic             press;
    logic [3:0]       digit;
    logic [CntW-1:0]  prescale_q, prescale_d;
    logic [BeepW-1:0] beep_q, beep_d;
    logic [3:0]       data_d;
    logic             loadn_d, timer_clear_d, en_d, mag_on_d, done_beep_d;

    // Keypad is registered once before edge detection, so a press shows up two edges later.
    always_comb begin
        digit = '0;
        for (int k = 0; k < 10; k++) begin
            if (key_s_q[k]) digit = 4'(k);
        end
        press = (state_q == StSet) && $onehot(key_s_q) && (key_prev_q == '0);
    end

    // State register
    always_ff @(posedge clock) begin
        if (clearn) begin
            state_q <= StSet;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop always takes priority over start
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSet: begin
                if (stopn && !startn && door_closed && !timer_zero) state_d = StCooking;
            end
            StCooking: begin
                if (!stopn || !door_closed) state_d = StPaused;
                else if (timer_zero)        state_d = StDone;
            end
            StPaused: begin
                if (!stopn)                    state_d = StSet;
                else if (!startn && door_closed) state_d = StCooking;
            end
            StDone: begin
                if (!stopn || beep_q == BeepMax) state_d = StSet;
            end
            default: state_d = StSet;
        endcase
    end

    // Output and counter next-state logic
    always_comb begin
        prescale_d = prescale_q;
        en_d       = 1'b0;
        if (state_d == StSet || state_d == StDone) begin
            prescale_d = '0;
        end else if (state_q == StCooking && state_d == StCooking) begin
            // Only advance while staying in COOKING so a pause keeps the partial second.
            prescale_d = (prescale_q == CntMax) ? '0 : prescale_q + 1'b1;
            en_d       = (prescale_q == CntMax) && !timer_zero;
        end

        beep_d        = (state_q == StDone && state_d == StDone) ? beep_q + 1'b1 : '0;
        timer_clear_d = !stopn && (state_q == StSet || state_q == StPaused);
        mag_on_d      = (state_d == StCooking);
        done_beep_d   = (state_d == StDone);
        loadn_d       = !press;
        data_d        = press ? digit : data;
    end

    always_ff @(posedge clock) begin
        if (clearn) begin
            key_s_q     <= '0;
            key_prev_q  <= '0;
            prescale_q  <= '0;
            beep_q      <= '0;
            data        <= '0;
            loadn       <= 1'b1;
            timer_clear <= 1'b0;
            en          <= 1'b0;
            mag_on      <= 1'b0;
            done_beep   <= 1'b0;
        end else begin
            key_s_q     <= keypad;
            key_prev_q  <= key_s_q;
            prescale_q  <= prescale_d;
            beep_q      <= beep_d;
            data        <= data_d;
            loadn       <= loadn_d;
            timer_clear <= timer_clear_d;
            en          <= en_d;
            mag_on      <= mag_on_d;
            done_beep   <= done_beep_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_microwave_control.sv
// Self-checking bench for microwave_control with a short prescaler (4 ticks/s, 2 s beep).
module tb_microwave_control;

    logic       clock = 1'b0;
    logic       clearn;
    logic [9:0] keypad;
    logic       startn, stopn, door_closed, timer_zero;
    logic [3:0] data;
    logic       loadn, timer_clear, en, mag_on, done_beep;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    int load_count = 0;
    int base;
    logic prev_loadn = 1'b1;
    int exp_d;
    int exp_q[$];

    microwave_control #(
        .TICKS_PER_SEC(4),
        .BEEP_SECS    (2)
    ) dut (
        .clock      (clock),
        .clearn     (clearn),
        .keypad     (keypad),
        .startn     (startn),
        .stopn      (stopn),
        .door_closed(door_closed),
        .timer_zero (timer_zero),
        .data       (data),
        .loadn      (loadn),
        .timer_clear(timer_clear),
        .en         (en),
        .mag_on     (mag_on),
        .done_beep  (done_beep),
        .state      (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Scoreboard consumer: every load strobe must match the oldest pushed digit.
    always @(negedge clock) begin
        if (!clearn) begin
            if (!loadn) begin
                load_count++;
                check("loadn_width", prev_loadn, 1);
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_d = exp_q.pop_front();
                    check("load_data", data, exp_d);
                end
            end
            prev_loadn = loadn;
        end
    end

    task automatic press(input int d);
        keypad = 10'(1) << d;
        exp_q.push_back(d);
        tick(1);
        check("press_no_early_load", loadn, 1);
        tick(1);
        check("press_loadn_low", loadn, 0);
        check("press_data", data, d);
        keypad = '0;
        tick(1);
        check("press_loadn_high", loadn, 1);
        tick(2);
    endtask

    task automatic start_cook();
        startn = 1'b0;
        tick(1);
        startn = 1'b1;
        check("start_state", state, 1);
    endtask

    initial begin
        clearn = 1'b1; keypad = '0; startn = 1'b1; stopn = 1'b1;
        door_closed = 1'b1; timer_zero = 1'b0;
        tick(2);
        check("rst_state", state, 0);
        check("rst_data", data, 0);
        check("rst_loadn", loadn, 1);
        check("rst_timer_clear", timer_clear, 0);
        check("rst_en", en, 0);
        check("rst_mag_on", mag_on, 0);
        check("rst_done_beep", done_beep, 0);
        clearn = 1'b0;
        tick(2);

        // Keypad entry
        press(1);
        press(3);
        press(0);

        base = load_count;
        keypad = 10'(1) << 5;
        exp_q.push_back(5);
        tick(10);
        keypad = '0;
        tick(3);
        check("hold_single", load_count - base, 1);

        base = load_count;
        keypad = 10'b0000100100;
        tick(4);
        keypad = '0;
        tick(3);
        check("multi_hot_ignored", load_count - base, 0);

        base = load_count;
        keypad = 10'(1) << 2;
        exp_q.push_back(2);
        tick(3);
        keypad = 10'(1) << 7;
        tick(3);
        keypad = '0;
        tick(3);
        check("key_change_no_zero", load_count - base, 1);

        // Cooking with en cadence; a key press in COOKING is ignored
        start_cook();
        check("cook_mag_on", mag_on, 1);
        base = load_count;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) keypad = 10'(1) << 9;
            if (k == 5) keypad = '0;
            tick(1);
            check("cook_en", en, (k % 4) == 0);
        end
        check("cook_key_ignored", load_count - base, 0);

        // Pause with partial second preserved
        tick(2);
        door_closed = 1'b0;
        tick(1);
        check("pause_state", state, 2);
        check("pause_mag_on", mag_on, 0);
        check("pause_en", en, 0);
        tick(3);
        check("pause_hold_state", state, 2);
        door_closed = 1'b1;
        start_cook();
        check("resume_mag_on", mag_on, 1);
        tick(1);
        check("resume_en_wait", en, 0);
        tick(1);
        check("resume_en_first", en, 1);

        // Countdown end and beep
        timer_zero = 1'b1;
        tick(1);
        check("done_state", state, 3);
        check("done_mag_on", mag_on, 0);
        check("done_beep_on", done_beep, 1);
        check("done_en", en, 0);
        for (int k = 1; k < 8; k++) begin
            tick(1);
            check("done_beep_hold", done_beep, 1);
            check("done_state_hold", state, 3);
        end
        tick(1);
        check("done_exit_state", state, 0);
        check("done_exit_beep", done_beep, 0);

        startn = 1'b0;
        tick(1);
        startn = 1'b1;
        check("start_blocked_zero", state, 0);
        timer_zero = 1'b0;
        door_closed = 1'b0;
        startn = 1'b0;
        tick(1);
        startn = 1'b1;
        check("start_blocked_door", state, 0);
        door_closed = 1'b1;

        start_cook();
        timer_zero = 1'b1;
        tick(1);
        check("done2_state", state, 3);
        stopn = 1'b0;
        tick(1);
        stopn = 1'b1;
        check("done_stop_state", state, 0);
        check("done_stop_no_clear", timer_clear, 0);
        timer_zero = 1'b0;

        // Stop priority and clears
        stopn = 1'b0; startn = 1'b0;
        tick(1);
        stopn = 1'b1; startn = 1'b1;
        check("set_stop_clear", timer_clear, 1);
        check("set_stop_state", state, 0);
        tick(1);
        check("set_clear_pulse_end", timer_clear, 0);

        start_cook();
        door_closed = 1'b0;
        tick(1);
        check("pause2_state", state, 2);
        door_closed = 1'b1;
        stopn = 1'b0;
        tick(1);
        stopn = 1'b1;
        check("paused_stop_state", state, 0);
        check("paused_stop_clear", timer_clear, 1);

        start_cook();
        door_closed = 1'b0; timer_zero = 1'b1;
        tick(1);
        check("door_beats_zero", state, 2);
        check("door_beats_zero_beep", done_beep, 0);
        door_closed = 1'b1; timer_zero = 1'b0;
        stopn = 1'b0;
        tick(1);
        stopn = 1'b1;

        start_cook();
        clearn = 1'b1;
        tick(1);
        check("reset_cook_state", state, 0);
        check("reset_cook_mag_on", mag_on, 0);
        clearn = 1'b0;
        tick(2);

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
